// File: rtl/slc3_sram_responder.sv
// slc3_sram_responder
//
// Memory-side target for the SLC-3 SRAM bus. On-chip word storage stands in
// for the external SRAM. After reset the block steps through a fixed
// power-up sequence:
//   CLEAR - zero-fill every word, one word per cycle
//   LOAD  - accept the program image over a valid/ready port
//   SERVE - answer CPU reads and writes
// A reset returns the block to CLEAR from any state.
//
// Parameters:
//   ADDR_W          storage index width (1..15); DEPTH = 2**ADDR_W words
//
// Ports:
//   Clk             system clock, rising edge
//   Reset           asynchronous, active-high reset
//   ADDR            CPU word address (MAR)
//   OE              CPU read enable, active low
//   WE              CPU write enable, active low (wins over OE)
//   Data_to_SRAM    CPU write data (MDR)
//   Data_from_SRAM  registered read data back to the CPU
//   Load_Valid      loader word valid
//   Load_Data       loader word
//   Load_Last       final loader word, only meaningful with Load_Valid
//   Load_Ready      high while loader words are accepted (LOAD state)
//   Init_Done       high once the CPU is being served
module slc3_sram_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_to_SRAM,
  output logic [15:0] Data_from_SRAM,
  input  logic        Load_Valid,
  input  logic [15:0] Load_Data,
  input  logic        Load_Last,
  output logic        Load_Ready,
  output logic        Init_Done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] load_ptr;

  logic [15:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;

  logic              load_xfer;
  logic              cpu_in_range;
  logic [ADDR_W-1:0] cpu_idx;
  logic              cpu_wr;
  logic              cpu_rd;

  // Any address with a bit set above the storage index (the I/O page
  // included) has no backing word: writes to it are dropped and reads
  // return zero rather than aliasing onto a low word.
  assign cpu_in_range = ((ADDR >> ADDR_W) == 16'd0);
  assign cpu_idx      = ADDR[ADDR_W-1:0];

  // Load_Ready is high exactly while the registered state is LOAD, so it
  // doubles as the handshake qualifier.
  assign load_xfer = Load_Ready & Load_Valid;

  // A write (WE low) always beats a read, even when OE is also low.
  assign cpu_wr = (state == ST_SERVE) & ~WE;
  assign cpu_rd = (state == ST_SERVE) & WE & ~OE;

  // Next-state logic. LOAD ends on a flagged last word or when the final
  // storage word has been filled, so the load pointer never wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: begin
        if (clr_cnt == '1) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_xfer && (Load_Last || load_ptr == '1)) begin
          state_nxt = ST_SERVE;
        end
      end
      ST_SERVE: begin
        state_nxt = ST_SERVE;
      end
      default: begin
        state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Single write port. The three writers (clear walker, loader, CPU) each
  // own the port in exactly one state, so selecting by state is enough.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = 16'h0000;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = 16'h0000;
      end
      ST_LOAD: begin
        mem_we    = load_xfer;
        mem_waddr = load_ptr;
        mem_wdata = Load_Data;
      end
      ST_SERVE: begin
        mem_we    = cpu_wr & cpu_in_range;
        mem_waddr = cpu_idx;
        mem_wdata = Data_to_SRAM;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // State register plus the registered status outputs. The status flags
  // are decoded from the next state so they change on the same edge the
  // state does.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_CLEAR;
      Load_Ready <= 1'b0;
      Init_Done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      Load_Ready <= (state_nxt == ST_LOAD);
      Init_Done  <= (state_nxt == ST_SERVE);
    end
  end

  // Clear walker and loader pointer. Both restart from zero on reset so a
  // reset mid-load wipes and reloads the image from the first word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clr_cnt  <= '0;
      load_ptr <= '0;
    end else begin
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      if (load_xfer && load_ptr != '1) begin
        load_ptr <= load_ptr + 1'b1;
      end
    end
  end

  // Storage array. Left without reset so it maps onto block RAM; its
  // contents are re-initialised by the CLEAR walk instead.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read data. It only changes on a SERVE read; writes, idle
  // cycles and the CLEAR/LOAD phases all hold it (at zero before SERVE).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Data_from_SRAM <= 16'h0000;
    end else if (cpu_rd) begin
      Data_from_SRAM <= cpu_in_range ? mem[cpu_idx] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_slc3_sram_responder.sv
// tb_slc3_sram_responder
//
// Directed bench for slc3_sram_responder with ADDR_W = 4 (16 words).
// Inputs change 1 ns after a rising edge and outputs are sampled at that
// same point, so every check sees the result of the preceding edge.
module tb_slc3_sram_responder;

  logic        Clk;
  logic        Reset;
  logic [15:0] ADDR;
  logic        OE;
  logic        WE;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        Load_Valid;
  logic [15:0] Load_Data;
  logic        Load_Last;
  logic        Load_Ready;
  logic        Init_Done;

  int checks;
  int failures;

  slc3_sram_responder #(
    .ADDR_W(4)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ADDR(ADDR),
    .OE(OE),
    .WE(WE),
    .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM),
    .Load_Valid(Load_Valid),
    .Load_Data(Load_Data),
    .Load_Last(Load_Last),
    .Load_Ready(Load_Ready),
    .Init_Done(Init_Done)
  );

  // 10 ns clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance to 1 ns past the next rising edge.
  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  // Drive one cycle's worth of inputs, then let one edge act on them.
  task automatic applyStimulus(input logic oe, input logic we,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic lv, input logic [15:0] ld,
                               input logic ll);
    OE           = oe;
    WE           = we;
    ADDR         = addr;
    Data_to_SRAM = wdata;
    Load_Valid   = lv;
    Load_Data    = ld;
    Load_Last    = ll;
    stepCycle();
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Idle CPU and loader for one cycle.
  task automatic idleCycle();
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
  endtask

  // CPU read: the value is registered on the edge, so it is checked just
  // after that edge.
  task automatic readCheck(input string tag, input logic [15:0] addr,
                           input logic [15:0] expected);
    applyStimulus(1'b0, 1'b1, addr, 16'h0000, 1'b0, 16'h0000, 1'b0);
    checkOutput(tag, Data_from_SRAM, expected);
  endtask

  // Release reset and walk through the 16-cycle clear phase.
  task automatic releaseAndClear(input string tag);
    Reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idleCycle();
      checkOutput({tag, "_ready"}, {15'd0, Load_Ready}, (i == 16) ? 16'd1 : 16'd0);
      checkOutput({tag, "_done"}, {15'd0, Init_Done}, 16'd0);
      checkOutput({tag, "_data"}, Data_from_SRAM, 16'h0000);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    Reset        = 1'b1;
    OE           = 1'b1;
    WE           = 1'b1;
    ADDR         = 16'h0000;
    Data_to_SRAM = 16'h0000;
    Load_Valid   = 1'b0;
    Load_Data    = 16'h0000;
    Load_Last    = 1'b0;

    $display("[TB] reset and clear");
    stepCycle();
    stepCycle();
    checkOutput("rst_data", Data_from_SRAM, 16'h0000);
    checkOutput("rst_ready", {15'd0, Load_Ready}, 16'd0);
    checkOutput("rst_done", {15'd0, Init_Done}, 16'd0);
    releaseAndClear("clr1");

    // Three words with one-cycle gaps. The CPU tries to read and write
    // address 0 the whole time; that must be ignored outside SERVE.
    $display("[TB] load with gaps");
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h3001, 1'b0);
    checkOutput("gap_w0_done", {15'd0, Init_Done}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
    checkOutput("gap_idle_ready", {15'd0, Load_Ready}, 16'd1);
    checkOutput("gap_idle_done", {15'd0, Init_Done}, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h4002, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    checkOutput("gap_cpu_data", Data_from_SRAM, 16'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h5003, 1'b1);
    checkOutput("gap_last_done", {15'd0, Init_Done}, 16'd1);
    checkOutput("gap_last_ready", {15'd0, Load_Ready}, 16'd0);
    checkOutput("gap_last_data", Data_from_SRAM, 16'h0000);
    readCheck("gap_rd0", 16'h0000, 16'h3001);
    readCheck("gap_rd1", 16'h0001, 16'h4002);
    readCheck("gap_rd2", 16'h0002, 16'h5003);
    readCheck("gap_rd3", 16'h0003, 16'h0000);

    $display("[TB] write then read");
    applyStimulus(1'b1, 1'b0, 16'h0007, 16'hBEEF, 1'b0, 16'h0000, 1'b0);
    checkOutput("wr_hold", Data_from_SRAM, 16'h0000);
    readCheck("wr_rd_beef", 16'h0007, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 16'h0007, 16'h1234, 1'b0, 16'h0000, 1'b0);
    checkOutput("wr_both_hold", Data_from_SRAM, 16'hBEEF);
    readCheck("wr_rd_1234", 16'h0007, 16'h1234);
    idleCycle();
    checkOutput("idle_hold", Data_from_SRAM, 16'h1234);

    $display("[TB] out of range");
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h5555, 1'b0, 16'h0000, 1'b0);
    readCheck("oor_rd_ffff", 16'hFFFF, 16'h0000);
    readCheck("oor_rd0_a", 16'h0000, 16'h3001);
    readCheck("oor_rd_0010", 16'h0010, 16'h0000);
    readCheck("oor_rd0_b", 16'h0000, 16'h3001);
    readCheck("oor_rd15", 16'h000F, 16'h0000);

    // Sixteen words without Load_Last fill storage and end the load.
    $display("[TB] load overflow");
    Reset = 1'b1;
    #1;
    checkOutput("ovf_rst_data", Data_from_SRAM, 16'h0000);
    checkOutput("ovf_rst_done", {15'd0, Init_Done}, 16'd0);
    stepCycle();
    releaseAndClear("clr2");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h1000 + 16'(i), 1'b0);
      checkOutput("ovf_done", {15'd0, Init_Done}, (i == 15) ? 16'd1 : 16'd0);
      checkOutput("ovf_ready", {15'd0, Load_Ready}, (i == 15) ? 16'd0 : 16'd1);
    end
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'hDEAD, 1'b1);
    checkOutput("ovf_17_ready", {15'd0, Load_Ready}, 16'd0);
    checkOutput("ovf_17_done", {15'd0, Init_Done}, 16'd1);
    readCheck("ovf_rd0", 16'h0000, 16'h1000);
    readCheck("ovf_rd9", 16'h0009, 16'h1009);
    readCheck("ovf_rd15", 16'h000F, 16'h100F);

    $display("[TB] mid-load reset");
    Reset = 1'b1;
    stepCycle();
    releaseAndClear("clr3");
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h11AA, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'h22BB, 1'b0);
    checkOutput("mid_pre_ready", {15'd0, Load_Ready}, 16'd1);
    Load_Valid = 1'b0;
    Reset      = 1'b1;
    #1;
    checkOutput("mid_rst_ready", {15'd0, Load_Ready}, 16'd0);
    checkOutput("mid_rst_done", {15'd0, Init_Done}, 16'd0);
    checkOutput("mid_rst_data", Data_from_SRAM, 16'h0000);
    stepCycle();
    releaseAndClear("clr4");
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 16'hA0A0, 1'b1);
    checkOutput("mid_done", {15'd0, Init_Done}, 16'd1);
    readCheck("mid_rd0", 16'h0000, 16'hA0A0);
    readCheck("mid_rd1", 16'h0001, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
